nfc_req_arbiter: RTL

//  Shares the single NAND flash controller (nfcm_top) between NREQ host requesters.

---
 rtl/nfc_pkg.sv | 34 +++
 rtl/nfc_rr_pick.sv | 38 +++
 rtl/nfc_req_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/nfc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nfc_pkg : command codes, arbiter states and status bit positions
// Revision: 1.0
// ---------------------------------------------------------------------------
package nfc_pkg;

  localparam logic [2:0] NFC_WPA = 3'b001;
  localparam logic [2:0] NFC_RPA = 3'b010;
  localparam logic [2:0] NFC_RET = 3'b011;
  localparam logic [2:0] NFC_EBL = 3'b100;
  localparam logic [2:0] NFC_RID = 3'b101;

  localparam int STS_PERR = 0;
  localparam int STS_EERR = 1;
  localparam int STS_RERR = 2;
  localparam int STS_TMO  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_GUARD = 3'd3,
    ST_WAIT  = 3'd4,
    ST_ACK   = 3'd5
  } arb_state_t;

  function automatic logic cmd_is_valid(input logic [2:0] cmd);
    return (cmd == NFC_WPA) || (cmd == NFC_RPA) || (cmd == NFC_RET) ||
           (cmd == NFC_EBL) || (cmd == NFC_RID);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nfc_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nfc_rr_pick : combinational round-robin picker, first request at/after ptr
// Revision: 1.0
// ---------------------------------------------------------------------------
module nfc_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [IDXW-1:0] o_idx,
  output logic            o_valid
);

  localparam int SUMW = IDXW + 1;

  logic [SUMW-1:0] w_pos;

  // Walk offsets from the far end so the smallest offset from ptr wins last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_pos = {1'b0, i_ptr} + SUMW'(i);
      if (w_pos >= SUMW'(NREQ)) begin
        w_pos = w_pos - SUMW'(NREQ);
      end
      if (i_req[w_pos[IDXW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[IDXW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nfc_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nfc_req_arbiter : round-robin sharing of one NAND controller among NREQ hosts
// Revision: 1.0
// ---------------------------------------------------------------------------
module nfc_req_arbiter
  import nfc_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TMO_W   = 20,
  parameter int TMO_CYC = 1000000
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic [NREQ-1:0]    req,
  input  logic [3*NREQ-1:0]  req_cmd,
  input  logic [16*NREQ-1:0] req_rwa,
  output logic [NREQ-1:0]    ack,
  output logic [3:0]         ack_sts,
  output logic [NREQ-1:0]    bf_own,
  output logic               busy,
  output logic [2:0]         nfc_cmd,
  output logic [15:0]        RWA,
  output logic               nfc_strt,
  input  logic               nfc_done,
  input  logic               PErr,
  input  logic               EErr,
  input  logic               RErr
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      r_state;
  arb_state_t      w_next;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] r_ptr;
  logic [TMO_W-1:0] r_cnt;
  logic [3:0]      r_sts;
  logic [2:0]      r_cmd;
  logic [15:0]     r_rwa;

  logic [IDXW-1:0] w_pick_idx;
  logic            w_pick_vld;
  logic [2:0]      w_win_cmd;
  logic [15:0]     w_win_rwa;
  logic            w_tmo_hit;
  logic [NREQ-1:0] w_onehot;
  logic            w_owning;

  nfc_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  assign w_win_cmd = req_cmd[3*int'(r_idx) +: 3];
  assign w_win_rwa = req_rwa[16*int'(r_idx) +: 16];
  assign w_tmo_hit = (r_cnt == TMO_W'(TMO_CYC - 1));
  assign w_onehot  = NREQ'(1) << r_idx;
  assign w_owning  = (r_state == ST_GRANT) || (r_state == ST_START) ||
                     (r_state == ST_GUARD) || (r_state == ST_WAIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_pick_vld) w_next = ST_GRANT;
      ST_GRANT: w_next = cmd_is_valid(w_win_cmd) ? ST_START : ST_ACK;
      ST_START: w_next = ST_GUARD;
      // nfc_done is still the previous operation's flag here.
      ST_GUARD: w_next = ST_WAIT;
      ST_WAIT:  if (nfc_done || w_tmo_hit) w_next = ST_ACK;
      ST_ACK:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_sts   <= '0;
      r_cmd   <= '0;
      r_rwa   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) r_idx <= w_pick_idx;
        end
        ST_GRANT: begin
          r_cmd <= w_win_cmd;
          r_rwa <= w_win_rwa;
          r_sts <= '0;
        end
        ST_START: r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // Done takes precedence when it coincides with the timeout.
          if (nfc_done) begin
            r_sts <= '0;
            r_sts[STS_PERR] <= PErr;
            r_sts[STS_EERR] <= EErr;
            r_sts[STS_RERR] <= RErr;
          end else if (w_tmo_hit) begin
            r_sts <= '0;
            r_sts[STS_TMO] <= 1'b1;
          end
        end
        ST_ACK: begin
          r_ptr <= (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign nfc_strt = (r_state == ST_START);
  assign busy     = (r_state != ST_IDLE);
  assign bf_own   = w_owning ? w_onehot : '0;
  assign ack      = (r_state == ST_ACK) ? w_onehot : '0;
  assign ack_sts  = (r_state == ST_ACK) ? r_sts : '0;
  assign nfc_cmd  = r_cmd;
  assign RWA      = r_rwa;

endmodule
`default_nettype wire
